keccak_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one Keccak permutation unit among N_REQ requesters.
//  The shared unit takes a 1600-bit state in and returns a 1600-bit state with a done pulse.

---
 rtl/keccak_rr_arbiter_if.sv | 29 ++
 rtl/keccak_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_keccak_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_rr_arbiter_if.sv
// Bundle between requesters / Keccak permutation unit and the round-robin arbiter.
// The arbiter connects through the slave modport.
interface keccak_rr_arbiter_if #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned D_WIDTH = 1600
);
  logic [N_REQ-1:0]         req_i;
  logic [N_REQ*D_WIDTH-1:0] din_i;
  logic [N_REQ-1:0]         gnt_o;
  logic [N_REQ-1:0]         done_o;
  logic [N_REQ-1:0]         err_o;
  logic [D_WIDTH-1:0]       dout_o;
  logic                     busy_o;
  logic                     ready_i;
  logic                     start_o;
  logic [D_WIDTH-1:0]       pdin_o;
  logic                     status_i;
  logic [D_WIDTH-1:0]       pdout_i;

  modport slave (
    input  req_i, din_i, ready_i, status_i, pdout_i,
    output gnt_o, done_o, err_o, dout_o, busy_o, start_o, pdin_o
  );

  modport master (
    output req_i, din_i, ready_i, status_i, pdout_i,
    input  gnt_o, done_o, err_o, dout_o, busy_o, start_o, pdin_o
  );
endinterface

// File: rtl/keccak_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one Keccak permutation unit among N_REQ
// requesters, with a watchdog that aborts a permutation that never completes.
module keccak_rr_arbiter #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned D_WIDTH = 1600,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  keccak_rr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP,
    S_ABORT
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic [WD_W-1:0]    wd_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic [N_REQ-1:0]   err_q;
  logic               start_q;
  logic               busy_q;
  logic [D_WIDTH-1:0] dout_q;
  logic [D_WIDTH-1:0] pdin_q;

  logic [IDX_W-1:0]   winner;
  logic               found;
  logic [D_WIDTH-1:0] din_sel;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Search starts one past the last owner and wraps, so the last owner ranks lowest.
  always_comb begin
    int unsigned cand;
    cand   = 0;
    winner = ptr_q;
    found  = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && bus.req_i[IDX_W'(cand)]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    din_sel = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (winner == IDX_W'(k)) din_sel = bus.din_i[k*D_WIDTH +: D_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      pdin_q  <= '0;
    end else begin
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found && bus.ready_i) begin
            owner_q <= winner;
            pdin_q  <= din_sel;
            gnt_q   <= onehot(winner);
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_q    <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          // Completion takes priority over a watchdog expiring in the same cycle.
          if (bus.status_i) begin
            dout_q  <= bus.pdout_i;
            done_q  <= onehot(owner_q);
            state_q <= S_RESP;
          end else if (wd_q == WD_LAST) begin
            err_q   <= onehot(owner_q);
            state_q <= S_ABORT;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        S_RESP, S_ABORT: begin
          ptr_q   <= owner_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.start_o = start_q;
  assign bus.busy_o  = busy_q;
  assign bus.dout_o  = dout_q;
  assign bus.pdin_o  = pdin_q;
endmodule

// File: tb/tb_keccak_rr_arbiter.sv
// Scoreboard bench for keccak_rr_arbiter: the driver predicts each grant/done/err
// event with its cycle, a negedge monitor pops and compares what the DUT presents.
module tb_keccak_rr_arbiter;
  localparam int N  = 2;
  localparam int DW = 1600;
  localparam int TO = 8;

  typedef enum int {EV_GNT, EV_DONE, EV_ERR} ev_e;
  typedef struct {
    int           cyc;
    ev_e          kind;
    logic [N-1:0] mask;
    logic [DW-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v    = '0;
  logic [N*DW-1:0] din_v    = '0;
  logic            ready_v  = 1'b0;
  logic            status_v = 1'b0;
  logic [DW-1:0]   pdout_v  = '0;

  keccak_rr_arbiter_if #(.N_REQ(N), .D_WIDTH(DW)) bus ();
  assign bus.req_i    = req_v;
  assign bus.din_i    = din_v;
  assign bus.ready_i  = ready_v;
  assign bus.status_i = status_v;
  assign bus.pdout_i  = pdout_v;

  keccak_rr_arbiter #(.N_REQ(N), .D_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  exp_busy = 1'b0;
  int  last = N - 1;
  logic [DW-1:0] dout_m = '0;
  bit  use_a5 = 1'b0;

  function automatic logic [N-1:0] onehot(input int i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  function automatic logic [DW-1:0] rand_dw();
    for (int i = 0; i < DW / 32; i++) rand_dw[i*32 +: 32] = $urandom;
  endfunction

  task automatic push_ev(input int c, input ev_e k, input logic [N-1:0] m, input logic [DW-1:0] d);
    ev_t ne;
    ne.cyc  = c;
    ne.kind = k;
    ne.mask = m;
    ne.data = d;
    sb.push_back(ne);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: busy every cycle, and every pulse on gnt/start/done/err against the queue.
  ev_t e;
  bit  ok;
  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (bus.busy_o !== exp_busy) begin
        miscompares++;
        $display("FAIL busy cyc=%0d: got %b expected %b", cyc, bus.busy_o, exp_busy);
      end
      if (|bus.gnt_o || |bus.done_o || |bus.err_o || bus.start_o) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected cyc=%0d: got gnt=%b start=%b done=%b err=%b, expected no event",
                   cyc, bus.gnt_o, bus.start_o, bus.done_o, bus.err_o);
        end else begin
          e  = sb.pop_front();
          ok = (e.cyc == cyc);
          case (e.kind)
            EV_GNT:  ok = ok && bus.gnt_o == e.mask && bus.start_o && bus.done_o == '0 &&
                          bus.err_o == '0 && bus.pdin_o == e.data;
            EV_DONE: ok = ok && bus.done_o == e.mask && !bus.start_o && bus.gnt_o == '0 &&
                          bus.err_o == '0 && bus.dout_o == e.data;
            default: ok = ok && bus.err_o == e.mask && !bus.start_o && bus.gnt_o == '0 &&
                          bus.done_o == '0 && bus.dout_o == e.data;
          endcase
          if (!ok) begin
            miscompares++;
            $display("FAIL %s: got cyc=%0d gnt=%b start=%b done=%b err=%b pdin[63:0]=%h dout[63:0]=%h, expected cyc=%0d mask=%b data[63:0]=%h",
                     e.kind.name(), cyc, bus.gnt_o, bus.start_o, bus.done_o, bus.err_o,
                     bus.pdin_o[63:0], bus.dout_o[63:0], e.cyc, e.mask, e.data[63:0]);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        e = sb.pop_front();
        $display("FAIL missing %s: got no event by cyc=%0d, expected at cyc=%0d mask=%b",
                 e.kind.name(), cyc, e.cyc, e.mask);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.gnt_o != '0 || bus.done_o != '0 || bus.err_o != '0 || bus.start_o ||
        bus.busy_o || bus.dout_o != '0 || bus.pdin_o != '0) begin
      miscompares++;
      $display("FAIL reset: got gnt=%b done=%b err=%b start=%b busy=%b dout[63:0]=%h pdin[63:0]=%h, expected all zero",
               bus.gnt_o, bus.done_o, bus.err_o, bus.start_o, bus.busy_o,
               bus.dout_o[63:0], bus.pdin_o[63:0]);
    end
    sb.delete();
    req_v    = '0;
    status_v = 1'b0;
    ready_v  = 1'b0;
    exp_busy = 1'b0;
    last     = N - 1;
    dout_m   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One transaction starting in an IDLE cycle. k in 1..TO: status after k busy
  // cycles; otherwise never (watchdog). rst_at>0 resets during that busy cycle.
  task automatic txn(input logic [N-1:0] mask, input int rdy_wait, input int k,
                     input bit hold, input int rst_at);
    int w;
    int c;
    logic [DW-1:0] pd;
    for (int j = 0; j < N; j++)
      if (mask[j] && !req_v[j]) din_v[j*DW +: DW] = rand_dw();
    req_v = req_v | mask;
    if (rdy_wait > 0) begin
      ready_v = 1'b0;
      repeat (rdy_wait) begin
        status_v = ($urandom_range(0, 3) == 0);
        tick();
        status_v = 1'b0;
      end
    end
    ready_v = 1'b1;
    w = -1;
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (last + i) % N;
      if (w < 0 && req_v[j]) w = j;
    end
    c = cyc + 1;
    push_ev(c, EV_GNT, onehot(w), din_v[w*DW +: DW]);
    tick();
    exp_busy = 1'b1;
    if (!hold) req_v[w] = 1'b0;
    ready_v = 1'($urandom_range(0, 1));
    for (int t = 1; t <= TO; t++) begin
      tick();
      pdout_v = rand_dw();
      if (rst_at == t) begin
        do_reset();
        return;
      end
      if (t == k) begin
        pd       = use_a5 ? {200{8'hA5}} : rand_dw();
        pdout_v  = pd;
        status_v = 1'b1;
        dout_m   = pd;
        push_ev(c + k + 1, EV_DONE, onehot(w), pd);
        tick();
        status_v = 1'($urandom_range(0, 1));
        pdout_v  = rand_dw();
        tick();
        status_v = 1'b0;
        exp_busy = 1'b0;
        last     = w;
        return;
      end
    end
    push_ev(c + TO + 1, EV_ERR, onehot(w), dout_m);
    tick();
    status_v = 1'($urandom_range(0, 1));
    tick();
    status_v = 1'b0;
    exp_busy = 1'b0;
    last     = w;
  endtask

  initial begin
    #1;
    do_reset();
    tick();

    use_a5 = 1'b1;
    txn(2'b01, 0, 3, 1'b0, 0);
    use_a5 = 1'b0;

    req_v = '0;
    for (int i = 0; i < 4; i++) txn(2'b11, 0, $urandom_range(1, 4), 1'b1, 0);
    req_v = '0;

    txn(2'b01, 0, 0, 1'b0, 0);
    txn(2'b11, 0, 2, 1'b0, 0);
    req_v = '0;

    txn(2'b10, 0, TO, 1'b0, 0);
    txn(2'b01, 10, 1, 1'b0, 0);

    req_v = '0;
    txn(2'b10, 0, TO, 1'b0, 3);
    repeat (3) begin
      status_v = 1'b1;
      pdout_v  = rand_dw();
      tick();
    end
    status_v = 1'b0;
    tick();
    txn(2'b11, 0, 0, 1'b0, 0);
    req_v = '0;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) req_v = '0;
      txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, TO),
          1'($urandom_range(0, 1)), 0);
    end

    req_v   = '0;
    ready_v = 1'b0;
    repeat (4) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d events still pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
